// File: rtl/load_store_format.sv
// Load/store lane formatter for a 32-bit RISC-V style memory port.
// Extracts and extends loaded bytes/halfwords from an aligned word, spreads
// store data across byte lanes with a matching write mask, and flags
// misaligned halfword/word accesses (optionally latched in a sticky flag).
module load_store_format #(
  parameter bit STICKY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mem_ctrl_i,
  input  logic [31:0] store_data_i,
  input  logic        access_valid_i,
  output logic [31:0] load_data_o,
  output logic [31:0] write_data_o,
  output logic [3:0]  write_mask_o,
  output logic        misaligned_o,
  output logic        sticky_err_o
);

  typedef enum logic [2:0] {
    CTRL_B  = 3'b000,
    CTRL_H  = 3'b001,
    CTRL_W  = 3'b010,
    CTRL_BU = 3'b100,
    CTRL_HU = 3'b101
  } ctrl_e;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes out of the memory word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_byte = mem_word_i[7:0];
    unique case (addr_lo_i)
      2'b00: w_byte = mem_word_i[7:0];
      2'b01: w_byte = mem_word_i[15:8];
      2'b10: w_byte = mem_word_i[23:16];
      2'b11: w_byte = mem_word_i[31:24];
      default: w_byte = mem_word_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  // Extend the selected lane according to the load size/sign; reserved codes pass the word through.
  always_comb begin
    load_data_o = mem_word_i;
    case (mem_ctrl_i)
      CTRL_B:  load_data_o = {{24{w_byte[7]}}, w_byte};
      CTRL_H:  load_data_o = {{16{w_half[15]}}, w_half};
      CTRL_W:  load_data_o = mem_word_i;
      CTRL_BU: load_data_o = {24'h0, w_byte};
      CTRL_HU: load_data_o = {16'h0, w_half};
      default: load_data_o = mem_word_i;
    endcase
  end

  // Replicate store data into lanes and build the byte mask; misaligned or reserved stores write nothing.
  always_comb begin
    write_data_o = store_data_i;
    write_mask_o = 4'b0000;
    misaligned_o = 1'b0;
    case (size_e'(mem_ctrl_i[1:0]))
      SIZE_B: begin
        write_data_o = {4{store_data_i[7:0]}};
        write_mask_o = 4'b0001 << addr_lo_i;
      end
      SIZE_H: begin
        write_data_o = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
        if (!addr_lo_i[0]) begin
          write_mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
      end
      SIZE_W: begin
        write_data_o = store_data_i;
        misaligned_o = (addr_lo_i != 2'b00);
        if (addr_lo_i == 2'b00) begin
          write_mask_o = 4'b1111;
        end
      end
      default: begin
        write_data_o = store_data_i;
        write_mask_o = 4'b0000;
      end
    endcase
  end

  generate
    if (STICKY_EN) begin : g_sticky
      logic r_sticky_err;

      // Latch any valid misaligned access until reset; reset wins over set.
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
          r_sticky_err <= 1'b0;
        end else if (access_valid_i && misaligned_o) begin
          r_sticky_err <= 1'b1;
        end
      end

      assign sticky_err_o = r_sticky_err;
    end else begin : g_no_sticky
      assign sticky_err_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_load_store_format.sv
// Directed testbench for load_store_format: load extension, store lane
// placement, misalignment detection and the sticky error flag.
module tb_load_store_format;

  logic        clk;
  logic        rst;
  logic [31:0] mem_word_i;
  logic [1:0]  addr_lo_i;
  logic [2:0]  mem_ctrl_i;
  logic [31:0] store_data_i;
  logic        access_valid_i;
  logic [31:0] load_data_o;
  logic [31:0] write_data_o;
  logic [3:0]  write_mask_o;
  logic        misaligned_o;
  logic        sticky_err_o;

  int checks;
  int failures;

  load_store_format #(.STICKY_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_word_i     (mem_word_i),
    .addr_lo_i      (addr_lo_i),
    .mem_ctrl_i     (mem_ctrl_i),
    .store_data_i   (store_data_i),
    .access_valid_i (access_valid_i),
    .load_data_o    (load_data_o),
    .write_data_o   (write_data_o),
    .write_mask_o   (write_mask_o),
    .misaligned_o   (misaligned_o),
    .sticky_err_o   (sticky_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] word;
    logic [1:0]  addr;
    logic [2:0]  ctrl;
    logic [31:0] exp_load;
    logic        exp_mis;
  } load_vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  addr;
    logic [2:0]  ctrl;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    logic        exp_mis;
  } store_vec_t;

  task automatic drive(input logic [31:0] word, input logic [1:0] addr,
                       input logic [2:0] ctrl, input logic [31:0] sdata,
                       input logic valid);
    mem_word_i     = word;
    addr_lo_i      = addr;
    mem_ctrl_i     = ctrl;
    store_data_i   = sdata;
    access_valid_i = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h0, 2'b00, 3'b010, 32'h0, 1'b0);
    tick();
    tick();
    checks++;
    if (sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_sticky got=%b exp=0", sticky_err_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    load_vec_t v[15];
    v[0]  = '{32'h8899AABB, 2'b01, 3'b000, 32'hFFFFFFAA, 1'b0};
    v[1]  = '{32'h8899AABB, 2'b01, 3'b100, 32'h000000AA, 1'b0};
    v[2]  = '{32'h8899AABB, 2'b10, 3'b001, 32'hFFFF8899, 1'b0};
    v[3]  = '{32'h8899AABB, 2'b10, 3'b101, 32'h00008899, 1'b0};
    v[4]  = '{32'h8899AABB, 2'b10, 3'b010, 32'h8899AABB, 1'b1};
    v[5]  = '{32'h8899AABB, 2'b00, 3'b000, 32'hFFFFFFBB, 1'b0};
    v[6]  = '{32'h8899AABB, 2'b10, 3'b000, 32'hFFFFFF99, 1'b0};
    v[7]  = '{32'h8899AABB, 2'b11, 3'b100, 32'h00000088, 1'b0};
    v[8]  = '{32'h8899AABB, 2'b00, 3'b001, 32'hFFFFAABB, 1'b0};
    v[9]  = '{32'h8899AABB, 2'b11, 3'b001, 32'hFFFF8899, 1'b1};
    v[10] = '{32'h12345678, 2'b00, 3'b001, 32'h00005678, 1'b0};
    v[11] = '{32'h7F000000, 2'b11, 3'b000, 32'h0000007F, 1'b0};
    v[12] = '{32'h8899AABB, 2'b01, 3'b011, 32'h8899AABB, 1'b0};
    v[13] = '{32'h8899AABB, 2'b11, 3'b110, 32'h8899AABB, 1'b1};
    v[14] = '{32'h8899AABB, 2'b01, 3'b111, 32'h8899AABB, 1'b0};
    for (int i = 0; i < 15; i++) begin
      drive(v[i].word, v[i].addr, v[i].ctrl, 32'h0, 1'b0);
      #1;
      checks++;
      if (load_data_o !== v[i].exp_load) begin
        failures++;
        $display("FAIL load[%0d] ctrl=%b addr=%b got=%h exp=%h", i, v[i].ctrl,
                 v[i].addr, load_data_o, v[i].exp_load);
      end
      checks++;
      if (misaligned_o !== v[i].exp_mis) begin
        failures++;
        $display("FAIL load_mis[%0d] got=%b exp=%b", i, misaligned_o, v[i].exp_mis);
      end
    end
  endtask

  task automatic test_store();
    store_vec_t v[12];
    v[0]  = '{32'h12345678, 2'b11, 3'b000, 32'h78787878, 4'b1000, 1'b0};
    v[1]  = '{32'h12345678, 2'b00, 3'b000, 32'h78787878, 4'b0001, 1'b0};
    v[2]  = '{32'h12345678, 2'b01, 3'b100, 32'h78787878, 4'b0010, 1'b0};
    v[3]  = '{32'h12345678, 2'b10, 3'b001, 32'h56785678, 4'b1100, 1'b0};
    v[4]  = '{32'h12345678, 2'b00, 3'b001, 32'h56785678, 4'b0011, 1'b0};
    v[5]  = '{32'h12345678, 2'b01, 3'b001, 32'h56785678, 4'b0000, 1'b1};
    v[6]  = '{32'h12345678, 2'b11, 3'b001, 32'h56785678, 4'b0000, 1'b1};
    v[7]  = '{32'h12345678, 2'b00, 3'b010, 32'h12345678, 4'b1111, 1'b0};
    v[8]  = '{32'h12345678, 2'b01, 3'b010, 32'h12345678, 4'b0000, 1'b1};
    v[9]  = '{32'h12345678, 2'b10, 3'b010, 32'h12345678, 4'b0000, 1'b1};
    v[10] = '{32'h12345678, 2'b00, 3'b011, 32'h12345678, 4'b0000, 1'b0};
    v[11] = '{32'hCAFEBABE, 2'b10, 3'b111, 32'hCAFEBABE, 4'b0000, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(32'h0, v[i].addr, v[i].ctrl, v[i].data, 1'b0);
      #1;
      checks++;
      if (write_data_o !== v[i].exp_wdata || write_mask_o !== v[i].exp_mask ||
          misaligned_o !== v[i].exp_mis) begin
        failures++;
        $display("FAIL store[%0d] ctrl=%b addr=%b got data=%h mask=%b mis=%b exp data=%h mask=%b mis=%b",
                 i, v[i].ctrl, v[i].addr, write_data_o, write_mask_o, misaligned_o,
                 v[i].exp_wdata, v[i].exp_mask, v[i].exp_mis);
      end
    end
  endtask

  task automatic test_sticky();
    // Misaligned but not valid: flag must stay clear.
    drive(32'h0, 2'b01, 3'b010, 32'h0, 1'b0);
    tick();
    checks++;
    if (sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL sticky_no_valid got=%b exp=0", sticky_err_o);
    end
    // Valid and aligned: flag must stay clear.
    drive(32'h0, 2'b00, 3'b010, 32'h0, 1'b1);
    tick();
    checks++;
    if (sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL sticky_aligned got=%b exp=0", sticky_err_o);
    end
    // Valid misaligned word access sets the flag on the next edge.
    drive(32'h0, 2'b01, 3'b010, 32'h12345678, 1'b1);
    #1;
    checks++;
    if (write_mask_o !== 4'b0000 || misaligned_o !== 1'b1 || sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL sticky_pre got mask=%b mis=%b sticky=%b exp mask=0000 mis=1 sticky=0",
               write_mask_o, misaligned_o, sticky_err_o);
    end
    tick();
    checks++;
    if (sticky_err_o !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set got=%b exp=1", sticky_err_o);
    end
    // Drop valid and go aligned: flag holds.
    drive(32'h0, 2'b00, 3'b000, 32'h0, 1'b0);
    tick();
    tick();
    checks++;
    if (sticky_err_o !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold got=%b exp=1", sticky_err_o);
    end
  endtask

  task automatic test_reset_priority();
    // Reset while a valid misaligned halfword access is present.
    drive(32'h8899AABB, 2'b11, 3'b001, 32'h12345678, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (load_data_o !== 32'hFFFF8899 || write_data_o !== 32'h56785678 ||
        write_mask_o !== 4'b0000 || misaligned_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_comb got load=%h wdata=%h mask=%b mis=%b exp load=ffff8899 wdata=56785678 mask=0000 mis=1",
               load_data_o, write_data_o, write_mask_o, misaligned_o);
    end
    tick();
    checks++;
    if (sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority got=%b exp=0", sticky_err_o);
    end
    rst = 1'b0;
    drive(32'h8899AABB, 2'b00, 3'b001, 32'h12345678, 1'b1);
    tick();
    checks++;
    if (sticky_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got=%b exp=0", sticky_err_o);
    end
    // Back-to-back: a misaligned valid access right after release sets it again.
    drive(32'h8899AABB, 2'b11, 3'b001, 32'h12345678, 1'b1);
    tick();
    checks++;
    if (sticky_err_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_reset_then_set got=%b exp=1", sticky_err_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(32'h0, 2'b00, 3'b000, 32'h0, 1'b0);
    test_reset();
    test_load();
    test_store();
    test_sticky();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
